// File: rtl/srec_pkg.sv
// Shared types for the S-record load controller.
// - load_state_t : controller FSM states
// - fifo_entry_t : one queued parser byte write {address, byte}
// - byte_enable  : one-hot byte lane select from a byte offset
package srec_pkg;

   typedef enum logic [1:0] {
      WAIT    = 2'd0,
      LOADING = 2'd1,
      RUN     = 2'd2,
      ERROR   = 2'd3
   } load_state_t;

   typedef struct packed {
      logic [31:0] address;
      logic [7:0]  data;
   } fifo_entry_t;

   localparam int unsigned FifoEntryWidth = $bits(fifo_entry_t);

   function automatic logic [3:0] byte_enable(input logic [1:0] offset);
      return 4'b0001 << offset;
   endfunction

endpackage

// File: rtl/srec_load_controller_if.sv
// Word-addressed memory request/response bus, used both for the CPU side and
// the RAM side of the load controller.
// - master : drives valid/we/addr/be/wdata, receives ready/rdata
// - slave  : receives the request, drives ready/rdata
interface srec_load_controller_if;

   logic        valid;
   logic        we;
   logic [29:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, we, addr, be, wdata,
      input  ready, rdata
   );

   modport slave (
      input  valid, we, addr, be, wdata,
      output ready, rdata
   );

endinterface

// File: rtl/srec_write_fifo.sv
// Synchronous FIFO with full/empty flags and a synchronous flush.
// - clock, reset : system clock, synchronous active-high reset
// - flush        : drop all entries
// - push/push_data : enqueue; accepted when not full or when popping
// - pop/pop_data   : dequeue; pop_data shows the head combinationally
// - full, empty    : occupancy flags
module srec_write_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrWidth = $clog2(DEPTH);

   logic [WIDTH-1:0]  storage_q [DEPTH];
   // Extra MSB distinguishes full from empty when the indices match.
   logic [PtrWidth:0] wr_ptr_q, rd_ptr_q;
   logic              push_ok, pop_ok;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                     (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
   assign pop_ok   = pop && !empty;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = storage_q[rd_ptr_q[PtrWidth-1:0]];

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) storage_q[wr_ptr_q[PtrWidth-1:0]] <= push_data;
   end

endmodule

// File: rtl/srec_load_controller.sv
// Sequences S-record parser byte writes into the shared RAM and arbitrates the
// RAM port between the loader and the CPU. Holds the CPU in reset while an
// image streams in, releases it after the UART line stays idle, and latches
// parser/overflow errors.
// - clock, reset           : system clock, synchronous active-high reset
// - char_ready             : UART character strobe (activity)
// - parser_write_*         : byte write strobe, byte address, byte data
// - parser_error           : parser sticky error
// - cpu_mem (slave)        : CPU memory bus
// - mem (master)           : RAM memory bus
// - cpu_reset, load_error  : CPU reset hold, sticky error indicator
// - bytes_loaded           : bytes committed in the current load, saturating
module srec_load_controller
   import srec_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    char_ready,
   input  logic                    parser_write_enable,
   input  logic [31:0]             parser_write_address,
   input  logic [7:0]              parser_write_byte,
   input  logic                    parser_error,
   srec_load_controller_if.slave   cpu_mem,
   srec_load_controller_if.master  mem,
   output logic                    cpu_reset,
   output logic                    load_error,
   output logic [15:0]             bytes_loaded
);

   localparam int unsigned IdleWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IdleWidth-1:0] IdleMax = IdleWidth'(TIMEOUT_CYCLES - 1);

   load_state_t          state_q, state_d;
   logic [IdleWidth-1:0] idle_q, idle_d;
   logic                 reload_pending_q, reload_pending_d;
   logic [15:0]          bytes_q, bytes_d;
   logic                 cpu_reset_q;
   logic                 load_error_q;

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_flush;
   logic [FifoEntryWidth-1:0] fifo_head_bits;
   fifo_entry_t          fifo_in, fifo_head;
   logic                 loader_valid;
   logic                 overflow;

   assign fifo_in.address = parser_write_address;
   assign fifo_in.data    = parser_write_byte;
   assign fifo_head       = fifo_entry_t'(fifo_head_bits);

   assign fifo_push    = parser_write_enable && (state_q != ERROR);
   assign fifo_flush   = (state_q == ERROR);
   assign loader_valid = (state_q == LOADING) && !fifo_empty;
   assign fifo_pop     = loader_valid && mem.ready;
   assign overflow     = fifo_push && fifo_full && !fifo_pop;

   srec_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FifoEntryWidth)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state logic.
   always_comb begin
      state_d          = state_q;
      reload_pending_d = reload_pending_q;

      unique case (state_q)
         WAIT: begin
            if (char_ready) state_d = LOADING;
         end
         LOADING: begin
            // An empty FIFO in LOADING also means no loader request is open.
            if ((idle_q == IdleMax) && fifo_empty) state_d = RUN;
         end
         RUN: begin
            // A reload request waits until the CPU bus is between requests.
            if ((char_ready || reload_pending_q) && !cpu_mem.valid) begin
               state_d = LOADING;
            end else if (char_ready) begin
               reload_pending_d = 1'b1;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: state_d = WAIT;
      endcase

      if (parser_error || overflow) state_d = ERROR;
      if (state_d != RUN) reload_pending_d = 1'b0;
   end

   always_comb begin
      idle_d = idle_q;
      if (char_ready) begin
         idle_d = '0;
      end else if (idle_q != IdleMax) begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_comb begin
      bytes_d = bytes_q;
      if ((state_d == LOADING) && (state_q != LOADING)) begin
         bytes_d = '0;
      end else if (fifo_pop && (bytes_q != 16'hFFFF)) begin
         bytes_d = bytes_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= WAIT;
         idle_q           <= '0;
         reload_pending_q <= 1'b0;
         bytes_q          <= '0;
         cpu_reset_q      <= 1'b1;
         load_error_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         idle_q           <= idle_d;
         reload_pending_q <= reload_pending_d;
         bytes_q          <= bytes_d;
         cpu_reset_q      <= (state_q != RUN);
         load_error_q     <= load_error_q || (state_d == ERROR);
      end
   end

   // RAM port arbitration: CPU passes straight through in RUN, otherwise
   // the loader drives byte writes from the FIFO head.
   always_comb begin
      mem.valid     = loader_valid;
      mem.we        = 1'b1;
      mem.addr      = fifo_head.address[31:2];
      mem.be        = byte_enable(fifo_head.address[1:0]);
      mem.wdata     = {4{fifo_head.data}};
      cpu_mem.ready = 1'b0;
      cpu_mem.rdata = '0;
      if (state_q == RUN) begin
         mem.valid     = cpu_mem.valid;
         mem.we        = cpu_mem.we;
         mem.addr      = cpu_mem.addr;
         mem.be        = cpu_mem.be;
         mem.wdata     = cpu_mem.wdata;
         cpu_mem.ready = mem.ready;
         cpu_mem.rdata = mem.rdata;
      end
   end

   assign cpu_reset    = cpu_reset_q;
   assign load_error   = load_error_q;
   assign bytes_loaded = bytes_q;

endmodule

// File: tb/tb_srec_load_controller.sv
module tb_srec_load_controller;
   import srec_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        char_ready;
   logic        parser_write_enable;
   logic [31:0] parser_write_address;
   logic [7:0]  parser_write_byte;
   logic        parser_error;
   logic        cpu_reset;
   logic        load_error;
   logic [15:0] bytes_loaded;

   srec_load_controller_if cpu_bus ();
   srec_load_controller_if ram_bus ();

   srec_load_controller #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .char_ready           (char_ready),
      .parser_write_enable  (parser_write_enable),
      .parser_write_address (parser_write_address),
      .parser_write_byte    (parser_write_byte),
      .parser_error         (parser_error),
      .cpu_mem              (cpu_bus),
      .mem                  (ram_bus),
      .cpu_reset            (cpu_reset),
      .load_error           (load_error),
      .bytes_loaded         (bytes_loaded)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;
   // Expected loader beat: {we, addr[29:0], be[3:0], wdata[31:0]}
   logic [66:0] exp_q [$];

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      char_ready          = 1'b0;
      parser_write_enable = 1'b0;
      parser_error        = 1'b0;
      cpu_bus.valid       = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   // Drive one parser write (with UART activity) and optionally log the beat.
   task automatic write_byte(input logic [31:0] a, input logic [7:0] d, input bit expect_beat);
      char_ready           = 1'b1;
      parser_write_enable  = 1'b1;
      parser_write_address = a;
      parser_write_byte    = d;
      if (expect_beat) exp_q.push_back({1'b1, a[31:2], 4'b0001 << a[1:0], {4{d}}});
   endtask

   // Loader beat monitor, sampled mid-cycle before the accepting edge.
   always @(negedge clock) begin
      if (mon_en && !reset && ram_bus.valid && ram_bus.ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: observed addr %0h be %0h wdata %0h expected none",
                   ram_bus.addr, ram_bus.be, ram_bus.wdata);
         end
         if (exp_q.size() != 0) begin
            chk("ram_beat", {ram_bus.we, ram_bus.addr, ram_bus.be, ram_bus.wdata},
                exp_q.pop_front());
         end
      end
   end

   initial begin
      int n;
      parser_write_address = '0;
      parser_write_byte    = '0;
      cpu_bus.we           = 1'b0;
      cpu_bus.addr         = '0;
      cpu_bus.be           = '0;
      cpu_bus.wdata        = '0;
      ram_bus.ready        = 1'b1;
      ram_bus.rdata        = 32'h5A5A_A5A5;
      do_reset();

      // Reset state
      chk("rst_state", dut.state_q, WAIT);
      chk("rst_cpu_reset", cpu_reset, 1'b1);
      chk("rst_load_error", load_error, 1'b0);
      chk("rst_bytes", bytes_loaded, 16'd0);
      chk("rst_mem_valid", ram_bus.valid, 1'b0);
      chk("rst_cpu_ready", cpu_bus.ready, 1'b0);

      // Four byte writes to one word at full throughput
      mon_en = 1'b1;
      write_byte(32'h100, 8'h11, 1'b1); step();
      write_byte(32'h101, 8'h22, 1'b1); step();
      write_byte(32'h102, 8'h33, 1'b1); step();
      write_byte(32'h103, 8'h44, 1'b1); step();
      clear_inputs();

      // Idle timeout to RUN, counted from the last char_ready edge
      n = 0;
      while (n < 40) begin
         step();
         n++;
         if (dut.state_q == RUN) break;
      end
      chk("run_latency", n, 16);
      chk("load_queue_drained", exp_q.size(), 0);
      chk("load_bytes", bytes_loaded, 16'd4);
      chk("cpu_reset_lag", cpu_reset, 1'b1);
      step();
      chk("cpu_reset_release", cpu_reset, 1'b0);

      // CPU read passes through in RUN
      mon_en        = 1'b0;
      cpu_bus.valid = 1'b1;
      cpu_bus.we    = 1'b0;
      cpu_bus.addr  = 30'h40;
      cpu_bus.be    = 4'hF;
      #1;
      chk("cpu_pass_valid", ram_bus.valid, 1'b1);
      chk("cpu_pass_addr", {ram_bus.we, ram_bus.addr}, {1'b0, 30'h40});
      chk("cpu_pass_ready", cpu_bus.ready, 1'b1);
      chk("cpu_pass_rdata", cpu_bus.rdata, 32'h5A5A_A5A5);
      step();
      cpu_bus.valid = 1'b0;

      // Reload deferred while the CPU keeps a request up
      cpu_bus.valid = 1'b1; step();
      write_byte(32'h206, 8'h5C, 1'b1); step();
      clear_inputs(); cpu_bus.valid = 1'b1; step();
      chk("reload_deferred", dut.state_q, RUN);
      cpu_bus.valid = 1'b0; mon_en = 1'b1; step();
      chk("reload_entered", dut.state_q, LOADING);
      chk("reload_bytes_clear", bytes_loaded, 16'd0);
      repeat (4) step();
      chk("reload_queue_drained", exp_q.size(), 0);
      chk("reload_bytes", bytes_loaded, 16'd1);

      // Reset with two writes pending
      mon_en = 1'b0;
      ram_bus.ready = 1'b0;
      write_byte(32'h300, 8'hA1, 1'b0); step();
      write_byte(32'h301, 8'hA2, 1'b0); step();
      clear_inputs();
      chk("pending_valid", ram_bus.valid, 1'b1);
      reset = 1'b1; step(); reset = 1'b0;
      chk("midreset_state", dut.state_q, WAIT);
      chk("midreset_fifo_empty", dut.u_fifo.empty, 1'b1);
      chk("midreset_valid", ram_bus.valid, 1'b0);

      // Overflow: five pushes into a four-entry FIFO with RAM stalled
      for (int i = 0; i < 4; i++) begin
         write_byte(32'h400 + i, 8'h60 + 8'(i), 1'b0); step();
      end
      chk("fill_no_error", dut.state_q, LOADING);
      write_byte(32'h404, 8'h64, 1'b0); step();
      clear_inputs();
      chk("ovf_state", dut.state_q, ERROR);
      chk("ovf_load_error", load_error, 1'b1);
      ram_bus.ready = 1'b1;
      mon_en = 1'b1;
      char_ready = 1'b1;
      repeat (8) step();
      clear_inputs();
      chk("ovf_fifo_flushed", dut.u_fifo.empty, 1'b1);
      chk("ovf_no_valid", ram_bus.valid, 1'b0);
      chk("ovf_cpu_reset", cpu_reset, 1'b1);
      chk("ovf_sticky", dut.state_q, ERROR);

      // parser_error mid-load
      do_reset();
      write_byte(32'h500, 8'h77, 1'b1); step();
      clear_inputs();
      parser_error = 1'b1; step();
      parser_error = 1'b0;
      chk("perr_state", dut.state_q, ERROR);
      chk("perr_load_error", load_error, 1'b1);
      repeat (5) step();
      chk("perr_sticky", dut.state_q, ERROR);
      chk("perr_queue_drained", exp_q.size(), 0);
      do_reset();
      chk("perr_reset_state", dut.state_q, WAIT);
      chk("perr_reset_load_error", load_error, 1'b0);

      // Push and pop on a full FIFO in the same cycle is not an overflow
      ram_bus.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         write_byte(32'h600 + i, 8'h80 + 8'(i), 1'b1); step();
      end
      write_byte(32'h604, 8'h84, 1'b1);
      ram_bus.ready = 1'b1;
      step();
      clear_inputs();
      chk("full_pushpop_state", dut.state_q, LOADING);
      repeat (8) step();
      chk("full_pushpop_drained", exp_q.size(), 0);
      chk("full_pushpop_bytes", bytes_loaded, 16'd5);
      chk("full_pushpop_no_error", load_error, 1'b0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/srec_load_controller.md
# srec_load_controller

Sequences the byte writes produced by the S-record parser into the shared instruction/data memory and arbitrates that memory port between the loader and the CPU. Holds the CPU in reset while an image streams in over the UART, and releases it once the line has gone quiet. Latches parser errors and owns the error indicator. Sits between `srec_parser`, the CPU memory interface and the on-chip RAM.

## Interface
- `FIFO_DEPTH`, 4: write buffer entries, power of two, ≥2.
- `TIMEOUT_CYCLES`, 1000000: idle cycles after the last character before the load is declared complete.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `char_ready`  in  1  UART character strobe (activity indicator).
- `parser_write_enable`  in  1  parser byte write strobe.
- `parser_write_address`  in  32  byte address.
- `parser_write_byte`  in  8  byte data.
- `parser_error`  in  1  parser sticky error.
- `cpu_mem_valid`  in  1  CPU request.
- `cpu_mem_we`  in  1  CPU write.
- `cpu_mem_addr`  in  30  CPU word address.
- `cpu_mem_be`  in  4  CPU byte enables.
- `cpu_mem_wdata`  in  32  CPU write data.
- `cpu_mem_ready`  out  1  completion to CPU.
- `cpu_mem_rdata`  out  32  read data to CPU.
- `mem_valid`, `mem_we`  out  1 each  RAM request and write.
- `mem_addr`  out  30  RAM word address.
- `mem_be`  out  4  RAM byte enables.
- `mem_wdata`  out  32  RAM write data.
- `mem_ready`  in  1  RAM completion.
- `mem_rdata`  in  32  RAM read data.
- `cpu_reset`  out  1  holds the CPU in reset.
- `load_error`  out  1  sticky error.
- `bytes_loaded`  out  16  bytes committed in the current load, saturating at 0xFFFF.

## Operation
- States:
  - WAIT: after reset; CPU held in reset.
  - LOADING: loader owns RAM.
  - RUN: CPU owns RAM.
  - ERROR: terminal until reset.
- WAIT → LOADING on `char_ready`.
- LOADING → RUN when the idle counter reaches `TIMEOUT_CYCLES`-1, the FIFO is empty and no RAM request is outstanding.
- RUN → LOADING on `char_ready`, only in a cycle with `cpu_mem_valid`=0. Otherwise the transition is deferred. Parser writes arriving meanwhile are still queued.
- Entering LOADING clears `bytes_loaded`.
- Any of the following → ERROR, from any state:
  - `parser_error`=1;
  - a push into a full FIFO.
- In ERROR:
  - the FIFO is flushed;
  - no further RAM writes are issued;
  - `cpu_reset`=1 and `load_error`=1.
- Idle counter:
  - clears on every `char_ready`;
  - otherwise increments, saturating at `TIMEOUT_CYCLES`-1;
  - width ⌈log2(TIMEOUT_CYCLES)⌉.
- FIFO entry = {address[31:0], byte[7:0]}.
- Push: `parser_write_enable`=1 in WAIT, LOADING or RUN.
- Pop: `mem_valid`=1 and `mem_ready`=1 while the loader owns RAM.
- Loader RAM request, driven from the FIFO head:
  - `mem_addr` = address[31:2];
  - `mem_be` = 4'b0001 << address[1:0];
  - `mem_wdata` = byte replicated ×4;
  - `mem_we` = 1.
- Address bits above 31 are ignored, so there is no wrap handling.
- Each pop increments `bytes_loaded` with saturation.
- Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- Ownership:
  - In RUN, `mem_*` mirror `cpu_mem_*` combinationally, and `cpu_mem_ready`/`cpu_mem_rdata` mirror `mem_ready`/`mem_rdata`.
  - In all other states, `cpu_mem_ready`=0 and CPU requests are ignored.

## Timing
- Reset values:
  - state WAIT;
  - `cpu_reset`=1, `load_error`=0, `bytes_loaded`=0;
  - `mem_valid`=0, `cpu_mem_ready`=0;
  - FIFO empty, idle counter 0.
- All state, the FIFO, the counters, `cpu_reset` and `load_error` are registered.
- `cpu_reset` changes in the cycle after the state transition.
- Push-to-`mem_valid` latency: 1 cycle minimum (a push at cycle N is visible at cycle N+1).
- Throughput: 1 byte/cycle with `mem_ready` held high.
- Handshake rules:
  - `mem_valid` and the loader request fields stay stable until `mem_ready`.
  - `mem_valid` may only drop after an accepted beat.
- Reset mid-load discards the FIFO and the pending request; the next cycle is WAIT.
- `parser_error` and a LOADING→RUN condition in the same cycle: ERROR wins.

## Structure
- Package `srec_pkg`: state enum (`WAIT`/`LOADING`/`RUN`/`ERROR`), FIFO entry struct, byte-enable helper function.
- One sub-module `srec_write_fifo`: a synchronous FIFO parameterized by depth and width, with full/empty flags.
- Arbitration mux and FSM live in the top level.

## Test plan
- Reset, then 4 writes to 0x100–0x103 (bytes 11,22,33,44) with `mem_ready`=1 → RAM beats at word 0x40 with `mem_be` 1,2,4,8 and `mem_wdata` 0x11111111…0x44444444. `bytes_loaded`=4.
- After the last `char_ready`, no activity (bench uses `TIMEOUT_CYCLES`=16) → RUN after 16 idle cycles. `cpu_reset` falls 1 cycle later; a CPU read of word 0x40 returns `mem_rdata`.
- `mem_ready`=0 during 5 pushes with `FIFO_DEPTH`=4 → overflow → ERROR. `load_error`=1, `cpu_reset`=1, and there are no further `mem_valid` beats.
- `parser_error` pulse mid-load → ERROR next cycle; state persists until `reset`.
- In RUN with `cpu_mem_valid`=1 held for 3 cycles and a `char_ready` during them → LOADING entered only on the first cycle `cpu_mem_valid`=0. `bytes_loaded` clears.
- `reset` asserted with 2 FIFO entries pending → WAIT, FIFO empty, `mem_valid`=0.
